// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: oversampled SPI-slave framer driving a byte-wide register port with auto-increment.
// Optional feature macro SPI_READBACK_EN enables read commands (reg_re/miso); otherwise reads are sunk.
module spi_reg_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ssel,
  input  logic              mosi,
  output logic              miso,
  output logic              reg_we,
  output logic              reg_re,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
`ifdef SPI_READBACK_EN
  localparam logic [2:0] ST_RDATA = 3'd3;
`else
  localparam logic [2:0] ST_SINK  = 3'd4;
`endif
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

  logic [1:0]        sclk_sync_r;
  logic [1:0]        ssel_sync_r;
  logic [1:0]        mosi_sync_r;
  logic              sclk_prev_r;
  logic              ssel_prev_r;
  logic              sclk_rise_s;
  logic              sclk_fall_s;
  logic              ssel_rise_s;
  logic              ssel_fall_s;
  logic              byte_done_s;
  logic [7:0]        byte_s;
  logic [2:0]        state_r;
  logic [2:0]        bit_cnt_r;
  logic [3:0]        byte_cnt_r;
  logic [7:0]        shift_r;
  logic              we_r;
  logic              re_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        wdata_r;
  logic              busy_r;

  // Two-flop synchronizers plus edge history; ssel resets high so a select held across reset is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= 2'b00;
      mosi_sync_r <= 2'b00;
      ssel_sync_r <= 2'b11;
      sclk_prev_r <= 1'b0;
      ssel_prev_r <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], sclk};
      mosi_sync_r <= {mosi_sync_r[0], mosi};
      ssel_sync_r <= {ssel_sync_r[0], ssel};
      sclk_prev_r <= sclk_sync_r[1];
      ssel_prev_r <= ssel_sync_r[1];
    end
  end

  // Edge detection and assembly of the byte completed by the current SCLK rise.
  always_comb begin
    sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
    sclk_fall_s = ~sclk_sync_r[1] & sclk_prev_r;
    ssel_rise_s = ssel_sync_r[1] & ~ssel_prev_r;
    ssel_fall_s = ~ssel_sync_r[1] & ssel_prev_r;
    byte_s      = {shift_r[6:0], mosi_sync_r[1]};
    byte_done_s = sclk_rise_s & (bit_cnt_r == 3'd7);
  end

  // Framing FSM: command decode, write strobes, read prefetch and address auto-increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 4'd0;
      shift_r    <= 8'h00;
      we_r       <= 1'b0;
      re_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 8'h00;
      busy_r     <= 1'b0;
    end else begin
      we_r <= 1'b0;
      re_r <= 1'b0;
      if (we_r) begin
        addr_r <= addr_r + ADDR_ONE;
      end
      // Deselect has priority, so a byte finishing in the same cycle is dropped.
      if (ssel_fall_s) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
      end else if (state_r == ST_IDLE) begin
        if (ssel_rise_s) begin
          state_r    <= ST_CMD;
          busy_r     <= 1'b1;
          bit_cnt_r  <= 3'd0;
          byte_cnt_r <= 4'd0;
          shift_r    <= 8'h00;
        end
      end else if (sclk_rise_s) begin
        shift_r   <= byte_s;
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (byte_done_s) begin
          if (byte_cnt_r != 4'd15) begin
            byte_cnt_r <= byte_cnt_r + 4'd1;
          end
          case (state_r)
            ST_CMD: begin
              addr_r <= byte_s[ADDR_W-1:0];
              if (byte_s[7]) begin
                state_r <= ST_WDATA;
              end else begin
`ifdef SPI_READBACK_EN
                re_r    <= 1'b1;
                state_r <= ST_RDATA;
`else
                state_r <= ST_SINK;
`endif
              end
            end
            ST_WDATA: begin
              wdata_r <= byte_s;
              we_r    <= 1'b1;
            end
`ifdef SPI_READBACK_EN
            ST_RDATA: begin
              addr_r <= addr_r + ADDR_ONE;
              re_r   <= 1'b1;
            end
`endif
            default: state_r <= state_r;
          endcase
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic       re_d1_r;
  logic [7:0] miso_sr_r;

  // Readback shifter: loads the cycle after reg_re; the fall that follows a byte boundary does not shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_d1_r   <= 1'b0;
      miso_sr_r <= 8'h00;
    end else begin
      re_d1_r <= re_r;
      if (ssel_fall_s) begin
        miso_sr_r <= 8'h00;
      end else if (re_d1_r && (state_r != ST_IDLE)) begin
        miso_sr_r <= reg_rdata;
      end else if (sclk_fall_s && (state_r == ST_RDATA) && (bit_cnt_r != 3'd0)) begin
        miso_sr_r <= {miso_sr_r[6:0], 1'b0};
      end else begin
        miso_sr_r <= miso_sr_r;
      end
    end
  end

  assign miso   = miso_sr_r[7];
  assign reg_re = re_r;
`else
  logic rdata_unused_s;
  assign rdata_unused_s = ^{reg_rdata, sclk_fall_s, re_r};
  assign miso   = 1'b0;
  assign reg_re = 1'b0;
`endif

  assign reg_we    = we_r;
  assign reg_addr  = addr_r;
  assign reg_wdata = wdata_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table-driven write bursts plus hand sequences for the timing corners.
module tb_spi_reg_ctrl;
  localparam int AW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk  = 1'b0;
  logic          ssel  = 1'b0;
  logic          mosi  = 1'b0;
  logic          miso;
  logic          reg_we;
  logic          reg_re;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic [7:0]    reg_rdata = 8'h00;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int both_cnt = 0;

  logic [7:0]    mem [0:15];
  logic [AW-1:0] we_addr_q[$];
  logic [7:0]    we_data_q[$];
  logic [AW-1:0] re_addr_q[$];
  logic          re_pend = 1'b0;
  logic [AW-1:0] re_pend_addr = '0;

  typedef struct {
    string      name;
    int         nb;
    logic [7:0] b0, b1, b2;
    int         nwe;
    logic [3:0] a0;
    logic [7:0] d0;
    logic [3:0] a1;
    logic [7:0] d1;
    logic [3:0] fa;
  } vec_t;

  vec_t vecs[5];

  spi_reg_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .ssel(ssel), .mosi(mosi), .miso(miso),
    .reg_we(reg_we), .reg_re(reg_re), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register-bank model (read data valid the cycle after reg_re) and strobe logger.
  always @(negedge clk) begin
    if (re_pend) reg_rdata = mem[re_pend_addr];
    else reg_rdata = 8'h00;
    re_pend = reg_re;
    re_pend_addr = reg_addr;
    if (reg_we) begin
      we_addr_q.push_back(reg_addr);
      we_data_q.push_back(reg_wdata);
      mem[reg_addr] = reg_wdata;
    end
    if (reg_re) re_addr_q.push_back(reg_addr);
    if (reg_we && reg_re) both_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      #50;
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      #50;
      sclk = 1'b0;
    end
  endtask

  task automatic clear_logs();
    we_addr_q.delete();
    we_data_q.delete();
    re_addr_q.delete();
  endtask

  function automatic vec_t mk(string n, int nb, logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                              int nwe, logic [3:0] a0, logic [7:0] d0, logic [3:0] a1,
                              logic [7:0] d1, logic [3:0] fa);
    vec_t v;
    v.name = n; v.nb = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.nwe = nwe; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.fa = fa;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [7:0] rx;
    logic [7:0] bytes [3];
    logic [3:0] ea [2];
    logic [7:0] ed [2];
    bytes[0] = v.b0; bytes[1] = v.b1; bytes[2] = v.b2;
    ea[0] = v.a0; ea[1] = v.a1; ed[0] = v.d0; ed[1] = v.d1;
    clear_logs();
    ssel = 1'b1;
    #50;
    for (int j = 0; j < v.nb; j++) spi_bits(bytes[j], 8, rx);
    #50;
    ssel = 1'b0;
    #60;
    chk({v.name, "_nwe"}, we_addr_q.size(), v.nwe);
    for (int k = 0; k < v.nwe; k++) begin
      chk({v.name, "_addr"}, (k < we_addr_q.size()) ? 32'(we_addr_q[k]) : 32'hFFFF, 32'(ea[k]));
      chk({v.name, "_data"}, (k < we_data_q.size()) ? 32'(we_data_q[k]) : 32'hFFFF, 32'(ed[k]));
    end
    chk({v.name, "_final_addr"}, reg_addr, v.fa);
    chk({v.name, "_busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] rx1;
    logic [7:0] rx2;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    vecs[0] = mk("burst",  3, 8'h83, 8'h11, 8'h22, 2, 4'h3, 8'h11, 4'h4, 8'h22, 4'h5);
    vecs[1] = mk("wrap",   3, 8'h8F, 8'hAA, 8'hBB, 2, 4'hF, 8'hAA, 4'h0, 8'hBB, 4'h1);
    vecs[2] = mk("addr0",  2, 8'h80, 8'h5C, 8'h00, 1, 4'h0, 8'h5C, 4'h0, 8'h00, 4'h1);
    vecs[3] = mk("hibits", 3, 8'hC7, 8'h3C, 8'hE1, 2, 4'h7, 8'h3C, 4'h8, 8'hE1, 4'h9);
    vecs[4] = mk("cmd_only", 1, 8'h8A, 8'h00, 8'h00, 0, 4'h0, 8'h00, 4'h0, 8'h00, 4'hA);

    // Reset values
    #20;
    chk("rst_we", reg_we, 1'b0);
    chk("rst_re", reg_re, 1'b0);
    chk("rst_addr", reg_addr, 4'h0);
    chk("rst_wdata", reg_wdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_miso", miso, 1'b0);
    rst_n = 1'b1;
    #40;

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // busy and write-strobe latency measured from the raw pin edges
    clear_logs();
    ssel = 1'b1;
    #20; chk("busy_rise_early", busy, 1'b0);
    #10; chk("busy_rise", busy, 1'b1);
    #20;
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h66, 7, rx);
    mosi = 1'b0;
    #50;
    sclk = 1'b1;
    #20; chk("we_lat_early", reg_we, 1'b0);
    #10; chk("we_lat", reg_we, 1'b1);
         chk("we_lat_addr", reg_addr, 4'h2);
         chk("we_lat_data", reg_wdata, 8'h66);
    #10; chk("we_width", reg_we, 1'b0);
         chk("we_addr_inc", reg_addr, 4'h3);
    #10; sclk = 1'b0;
    #50;
    ssel = 1'b0;
    #20; chk("busy_fall_early", busy, 1'b1);
    #10; chk("busy_fall", busy, 1'b0);
    chk("lat_nwe", we_addr_q.size(), 1);
    #40;

    // Abort a partial byte, then a normal write
    clear_logs();
    ssel = 1'b1;
    #50;
    spi_bits(8'h81, 8, rx);
    spi_bits(8'hFF, 5, rx);
    ssel = 1'b0;
    #30;
    chk("abort_busy", busy, 1'b0);
    chk("abort_nwe", we_addr_q.size(), 0);
    chk("abort_addr_hold", reg_addr, 4'h1);
    #30;
    run_vec(mk("after_abort", 2, 8'h81, 8'h77, 8'h00, 1, 4'h1, 8'h77, 4'h0, 8'h00, 4'h2));

    // SSEL fall coincident with the 8th data rise: byte dropped
    clear_logs();
    ssel = 1'b1;
    #50;
    spi_bits(8'h84, 8, rx);
    spi_bits(8'h55, 7, rx);
    mosi = 1'b1;
    #50;
    sclk = 1'b1;
    ssel = 1'b0;
    #50;
    sclk = 1'b0;
    #30;
    chk("coinc_nwe", we_addr_q.size(), 0);
    chk("coinc_busy", busy, 1'b0);
    chk("coinc_addr", reg_addr, 4'h4);
    #30;

`ifdef SPI_READBACK_EN
    mem[5] = 8'h5A;
    mem[6] = 8'hC3;
    clear_logs();
    ssel = 1'b1;
    #50;
    spi_bits(8'h05, 8, rx);
    spi_bits(8'h00, 8, rx1);
    spi_bits(8'h00, 8, rx2);
    #50;
    ssel = 1'b0;
    #60;
    chk("rd_byte0", rx1, 8'h5A);
    chk("rd_byte1", rx2, 8'hC3);
    chk("rd_nre", re_addr_q.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("rd_re_addr", (k < re_addr_q.size()) ? 32'(re_addr_q[k]) : 32'hFFFF, 32'(5 + k));
    chk("rd_nwe", we_addr_q.size(), 0);
`else
    clear_logs();
    ssel = 1'b1;
    #50;
    spi_bits(8'h02, 8, rx1);
    spi_bits(8'h99, 8, rx2);
    chk("sink_busy", busy, 1'b1);
    #50;
    ssel = 1'b0;
    #60;
    chk("sink_miso0", rx1, 8'h00);
    chk("sink_miso1", rx2, 8'h00);
    chk("sink_nwe", we_addr_q.size(), 0);
    chk("sink_nre", re_addr_q.size(), 0);
    chk("sink_busy_idle", busy, 1'b0);
`endif
    #40;

    // Reset in the middle of a data byte; traffic after release is ignored
    clear_logs();
    ssel = 1'b1;
    #50;
    spi_bits(8'h85, 8, rx);
    spi_bits(8'hF0, 4, rx);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", reg_we, 1'b0);
    chk("mid_rst_re", reg_re, 1'b0);
    chk("mid_rst_addr", reg_addr, 4'h0);
    chk("mid_rst_wdata", reg_wdata, 8'h00);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_miso", miso, 1'b0);
    #19;
    rst_n = 1'b1;
    spi_bits(8'h00, 4, rx);
    spi_bits(8'hA5, 8, rx);
    chk("post_rst_busy", busy, 1'b0);
    #50;
    ssel = 1'b0;
    #60;
    chk("post_rst_nwe", we_addr_q.size(), 0);
    chk("post_rst_nre", re_addr_q.size(), 0);
    chk("post_rst_addr", reg_addr, 4'h0);

    chk("we_re_overlap", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
